// File: rtl/gray_counter_param_pkg.sv
// Shared Gray-code helpers and types for the parametrised Gray counter and its
// converters. Functions work on the widest legal width; callers zero-extend.
package gray_counter_param_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    // Action chosen for the counter on a given clock edge.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'b00,
        STEP_LOAD = 2'b01,
        STEP_UP   = 2'b10,
        STEP_DOWN = 2'b11
    } step_e;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs convert correctly.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] gray
    );
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control and status bundle of the Gray counter. The master drives the
// step/load controls, the slave (the counter) returns its registered state.
interface gray_counter_param_if #(
    parameter int WIDTH = 3
) ();

    logic             En;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] LoadGray;
    logic             FlagClr;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Binary;
    logic             Overflow;
    logic             Underflow;
    logic             Wrap;

    modport master (
        output En, Dir, Load, LoadGray, FlagClr,
        input  Output, Binary, Overflow, Underflow, Wrap
    );

    modport slave (
        input  En, Dir, Load, LoadGray, FlagClr,
        output Output, Binary, Overflow, Underflow, Wrap
    );

endinterface

// File: rtl/gray_counter_param_gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position. Reusable by pointer syncs.
module gray2bin_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Reduction per bit keeps the net graph acyclic (no bit feeds its neighbour).
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with parallel Gray load, sticky wrap flags,
// a one-cycle wrap pulse and a registered binary shadow of the count.
module gray_counter_param
    import gray_counter_param_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] INIT_GRAY = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    gray_counter_param_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;
    logic             wrap_reg;
    logic             wrap_next;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] init_bin;
    logic             ovf_set;
    logic             unf_set;
    step_e            step;

    gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
        .gray (bus.LoadGray),
        .bin  (load_bin)
    );

    gray2bin_conv #(.WIDTH(WIDTH)) u_init_conv (
        .gray (INIT_GRAY),
        .bin  (init_bin)
    );

    // Load outranks a step; Dir only matters when stepping.
    always_comb begin
        step = STEP_HOLD;
        if (bus.Load) begin
            step = STEP_LOAD;
        end else if (bus.En) begin
            step = bus.Dir ? STEP_UP : STEP_DOWN;
        end
    end

    always_comb begin
        bin_next  = bin_reg;
        gray_next = gray_reg;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (step)
            STEP_LOAD: begin
                bin_next  = load_bin;
                gray_next = bus.LoadGray;
            end
            STEP_UP: begin
                bin_next  = bin_reg + 1'b1;
                ovf_set   = (bin_reg == ALL_ONES);
                gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
            end
            STEP_DOWN: begin
                bin_next  = bin_reg - 1'b1;
                unf_set   = (bin_reg == '0);
                gray_next = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
            end
            default: begin
                bin_next  = bin_reg;
                gray_next = gray_reg;
            end
        endcase
    end

    // A wrap on the same edge as FlagClr keeps its own flag set.
    always_comb begin
        wrap_next      = ovf_set | unf_set;
        overflow_next  = ovf_set | (overflow_reg  & ~bus.FlagClr);
        underflow_next = unf_set | (underflow_reg & ~bus.FlagClr);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bin_reg       <= init_bin;
            gray_reg      <= INIT_GRAY;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            wrap_reg      <= 1'b0;
        end else begin
            bin_reg       <= bin_next;
            gray_reg      <= gray_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            wrap_reg      <= wrap_next;
        end
    end

    assign bus.Output    = gray_reg;
    assign bus.Binary    = bin_reg;
    assign bus.Overflow  = overflow_reg;
    assign bus.Underflow = underflow_reg;
    assign bus.Wrap      = wrap_reg;

endmodule
